// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the MIPS memory bus controller.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } bus_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic op_is_store(mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Fetches are presented as OP_LW, so they share the word alignment rule.
  function automatic logic op_misaligned(mem_op_t op, logic [1:0] k);
    case (op)
      OP_LH, OP_LHU, OP_SH: return k[0];
      OP_LW, OP_SW:         return k != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_byte_en(mem_op_t op, logic [1:0] k);
    case (op)
      OP_LB, OP_LBU, OP_SB: return BE_BYTE << k;
      OP_LH, OP_LHU, OP_SH: return BE_HALF << {k[1], 1'b0};
      default:              return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] op_write_lanes(mem_op_t op, logic [31:0] w);
    case (op)
      OP_SB:   return {4{w[7:0]}};
      OP_SH:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load result formatting: lane extract, sign/zero extension, LWL/LWR merge.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;

  // Extract the addressed lane(s) and build the register result.
  always_comb begin
    byte_v   = rdata_i[{k_i, 3'b000} +: 8];
    half_v   = k_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    // 8*(3-k) and 8*k as shift amounts, without leaving 5 bits.
    sh_l     = {~k_i, 3'b000};
    sh_r     = {k_i, 3'b000};
    result_o = rdata_i;
    case (op_i)
      OP_LB:  result_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU: result_o = {24'h000000, byte_v};
      OP_LH:  result_o = {{16{half_v[15]}}, half_v};
      OP_LHU: result_o = {16'h0000, half_v};
      // Memory bytes 0..k land in the top of rt; rt keeps its low bytes.
      OP_LWL: result_o = (rdata_i << sh_l) | (rt_old_i & ~('1 << sh_l));
      // Memory bytes k..3 land in the bottom of rt; rt keeps its high bytes.
      OP_LWR: result_o = (rdata_i >> sh_r) | (rt_old_i & ~('1 >> sh_r));
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// Two-channel Avalon-MM master: data has priority over fetch, registered
// bus outputs, misalignment rejection and optional waitrequest timeout.
module mips_cpu_bus_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  input  logic              d_valid,
  input  logic [3:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [31:0]       d_rt_old,
  output logic              d_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  localparam int unsigned CNT_W = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);

  bus_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic              fetch_q, fetch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  mem_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              req_fetch;
  logic [31:0]       load_res;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout;

  mips_cpu_load_align u_align (
    .op_i     (op_q),
    .k_i      (k_q),
    .rdata_i  (readdata),
    .rt_old_i (rt_old_q),
    .result_o (load_res)
  );

  // Arbitration: data wins; a fetch is carried as a word load.
  always_comb begin
    req_fetch = !d_valid;
    req_op    = d_valid ? mem_op_t'(d_op) : OP_LW;
    req_addr  = d_valid ? d_addr : i_addr;
    cnt_inc   = cnt_q + CNT_W'(1);
    timeout   = (WAIT_MAX != 0) && (cnt_inc == CNT_W'(WAIT_MAX));
  end

  // Next-state and registered-output logic for IDLE/BUS/RESP.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    k_d         = k_q;
    rt_old_d    = rt_old_q;
    fetch_d     = fetch_q;
    cnt_d       = '0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    address_d   = '0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    be_d        = '0;
    wdata_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (d_valid || i_valid) begin
          fetch_d  = req_fetch;
          op_d     = req_op;
          k_d      = req_addr[1:0];
          rt_old_d = d_rt_old;
          if (op_misaligned(req_op, req_addr[1:0])) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
            i_ready_d = req_fetch;
            d_ready_d = !req_fetch;
          end else begin
            state_d   = S_BUS;
            read_d    = !op_is_store(req_op);
            write_d   = op_is_store(req_op);
            be_d      = op_byte_en(req_op, req_addr[1:0]);
            address_d = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = op_write_lanes(req_op, d_wdata);
          end
        end
      end
      S_BUS: begin
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        if (!waitrequest) begin
          state_d     = S_RESP;
          read_d      = 1'b0;
          write_d     = 1'b0;
          be_d        = '0;
          address_d   = '0;
          wdata_d     = '0;
          i_ready_d   = fetch_q;
          d_ready_d   = !fetch_q;
          rsp_rdata_d = op_is_store(op_q) ? 32'h0 : load_res;
        end else if (timeout) begin
          // Abandon the cycle even though the slave is still stalling.
          state_d   = S_RESP;
          read_d    = 1'b0;
          write_d   = 1'b0;
          be_d      = '0;
          address_d = '0;
          wdata_d   = '0;
          rsp_err_d = 1'b1;
          i_ready_d = fetch_q;
          d_ready_d = !fetch_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request latches and registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      k_q         <= '0;
      rt_old_q    <= '0;
      fetch_q     <= 1'b0;
      cnt_q       <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      k_q         <= k_d;
      rt_old_q    <= rt_old_d;
      fetch_q     <= fetch_d;
      cnt_q       <= cnt_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Bench for mips_cpu_bus_ctrl: a cycle-indexed expectation table built from
// byte-level rules, checked every cycle, plus directed timeout/reset cases.
module tb_mips_cpu_bus_ctrl;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Main DUT (no timeout)
  logic        i_valid, i_ready, d_valid, d_ready, rsp_err, read, write, waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, d_rt_old, rsp_rdata, address, writedata, readdata;
  logic [3:0]  d_op, byteenable;

  mips_cpu_bus_ctrl #(.ADDR_W(32), .WAIT_MAX(0)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .d_valid(d_valid), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rt_old(d_rt_old), .d_ready(d_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  // Second DUT with a 4-cycle stall limit
  logic        t_i_ready, t_d_valid, t_d_ready, t_rsp_err, t_read, t_write, t_waitrequest;
  logic [31:0] t_d_addr, t_rsp_rdata, t_address, t_writedata, t_readdata;
  logic [3:0]  t_d_op, t_byteenable;

  mips_cpu_bus_ctrl #(.ADDR_W(32), .WAIT_MAX(4)) dut_t (
    .clk(clk), .reset(reset),
    .i_valid(1'b0), .i_addr(32'h0), .i_ready(t_i_ready),
    .d_valid(t_d_valid), .d_op(t_d_op), .d_addr(t_d_addr), .d_wdata(32'h0),
    .d_rt_old(32'h0), .d_ready(t_d_ready),
    .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
    .address(t_address), .read(t_read), .write(t_write), .byteenable(t_byteenable),
    .writedata(t_writedata), .readdata(t_readdata), .waitrequest(t_waitrequest)
  );

  typedef struct {
    bit          rd, wr, irdy, drdy, err, wreq;
    logic [31:0] addr, wdata, rdin, rsp;
    logic [3:0]  be;
  } cyc_t;

  cyc_t sched [int];
  cyc_t ce;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit m_store(mem_op_t op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit m_mis(bit fetch, mem_op_t op, logic [31:0] a);
    if (fetch) return (a % 4) != 0;
    if (op == OP_LWL || op == OP_LWR) return 0;
    return (a % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(bit fetch, mem_op_t op, logic [31:0] a);
    int sz, st;
    logic [3:0] be;
    sz = fetch ? 4 : op_size(op);
    st = int'(a % 4) - int'(a % 4) % sz;
    be = '0;
    for (int j = 0; j < 4; j++) be[j] = (j >= st) && (j < st + sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(mem_op_t op, logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = op_size(op);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(mem_op_t op, logic [31:0] a, logic [31:0] rd, logic [31:0] rt);
    int k;
    logic [31:0] r;
    logic [7:0] b;
    logic [15:0] h;
    k = int'(a % 4);
    b = rd[8*k +: 8];
    h = rd[16*(k/2) +: 16];
    r = rt;
    case (op)
      OP_LB:  r = 32'($signed(b));
      OP_LBU: r = {24'h0, b};
      OP_LH:  r = 32'($signed(h));
      OP_LHU: r = {16'h0, h};
      OP_LW:  r = rd;
      OP_LWL: for (int i = 0; i < 4; i++) if (i >= 3 - k) r[8*i +: 8] = rd[8*(i-(3-k)) +: 8];
      OP_LWR: for (int i = 0; i < 4; i++) if (i <= 3 - k) r[8*i +: 8] = rd[8*(i+k) +: 8];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Fill the expectation table for one request accepted in cycle `start`.
  task automatic fill(input bit fetch, input mem_op_t op, input logic [31:0] a, wd, rt, rdv,
                      input int nst, input int start, output int r);
    cyc_t e;
    if (m_mis(fetch, op, a)) begin
      e = '{default:0};
      e.err = 1; e.irdy = fetch; e.drdy = !fetch;
      r = start + 1;
      sched[r] = e;
      return;
    end
    for (int c = start + 1; c <= start + 1 + nst; c++) begin
      e = '{default:0};
      e.rd    = fetch || !m_store(op);
      e.wr    = !e.rd;
      e.addr  = {a[31:2], 2'b00};
      e.be    = m_be(fetch, op, a);
      e.wdata = m_wdata(op, wd);
      e.wreq  = (c < start + 1 + nst);
      e.rdin  = e.wreq ? $urandom : rdv;
      sched[c] = e;
    end
    r = start + 2 + nst;
    e = '{default:0};
    e.irdy = fetch; e.drdy = !fetch;
    e.rsp  = fetch ? rdv : m_load(op, a, rdv, rt);
    sched[r] = e;
  endtask

  // Slave side: scheduled waitrequest/readdata, noise when no bus cycle is due.
  initial begin
    waitrequest = 1'b0;
    readdata    = '0;
    forever begin
      @(posedge clk); #2;
      if (sched.exists(cyc)) begin
        waitrequest = sched[cyc].wreq;
        readdata    = sched[cyc].rdin;
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
        readdata    = $urandom;
      end
    end
  end

  // Per-cycle comparison against the expectation table.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sched.exists(cyc)) ce = sched[cyc];
      else ce = '{default:0};
      check("read", read, ce.rd);
      check("write", write, ce.wr);
      check("i_ready", i_ready, ce.irdy);
      check("d_ready", d_ready, ce.drdy);
      if (ce.rd || ce.wr) begin
        check("address", address, ce.addr);
        check("byteenable", byteenable, ce.be);
      end
      if (ce.wr) check("writedata", writedata, ce.wdata);
      if (ce.irdy || ce.drdy) begin
        check("rsp_err", rsp_err, ce.err);
        if (!ce.err) check("rsp_rdata", rsp_rdata, ce.rsp);
      end
    end
  end

  // Issue a data and/or fetch request; returns observed valid-to-ready latencies.
  task automatic run_txn(input bit hd, input bit hi, input mem_op_t op,
                         input logic [31:0] da, ia, wd, rt, rdd, rdi,
                         input int nd, input int ni, output int lat_d, output int lat_i);
    int p, rd_r, ri_r, last, od, oi;
    @(posedge clk); #1;
    p = cyc; rd_r = -1; ri_r = -1; od = -1; oi = -1;
    if (hd) fill(0, op, da, wd, rt, rdd, nd, p, rd_r);
    if (hi) fill(1, OP_LW, ia, 32'h0, 32'h0, rdi, ni, hd ? rd_r + 1 : p, ri_r);
    d_valid = hd; d_op = op; d_addr = da; d_wdata = wd; d_rt_old = rt;
    i_valid = hi; i_addr = ia;
    last = (rd_r > ri_r) ? rd_r : ri_r;
    while (cyc <= last) begin
      @(posedge clk); #1;
      if (cyc == rd_r) d_valid = 1'b0;
      if (cyc == ri_r) i_valid = 1'b0;
      if (od < 0 && d_ready) od = cyc;
      if (oi < 0 && i_ready) oi = cyc;
    end
    lat_d = (od < 0) ? -1 : od - p + 1;
    lat_i = (oi < 0) ? -1 : oi - p + 1;
  endtask

  // Timeout instance: slave stalls `allow` bus cycles, then answers.
  task automatic tmo_run(input int allow, input logic [31:0] rdv, output int rd_hi,
                         output bit got, output logic err, output logic [31:0] data, output int lat);
    int p;
    @(posedge clk); #1;
    p = cyc;
    t_d_valid = 1'b1; t_d_op = OP_LW; t_d_addr = 32'h40; t_waitrequest = 1'b1; t_readdata = rdv;
    rd_hi = 0; got = 0; lat = -1; err = 1'bx; data = 'x;
    for (int c = 0; c < 12 && !got; c++) begin
      @(posedge clk); #1;
      if (t_read) begin
        rd_hi++;
        t_waitrequest = (rd_hi <= allow);
      end
      if (t_d_ready) begin
        got = 1; err = t_rsp_err; data = t_rsp_rdata; lat = cyc - p + 1;
        t_d_valid = 1'b0;
      end
    end
    t_d_valid = 1'b0;
    t_waitrequest = 1'b1;
    @(posedge clk); #1;
    check("tmo_ready_pulse_once", t_d_ready, 1'b0);
    check("tmo_idle_after", t_read, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld, li, rhi, p, r, n, mode;
    bit got, saw, hd, hi;
    logic err;
    logic [31:0] dat, da, ia;
    mem_op_t op;

    reset = 1'b1;
    i_valid = 0; i_addr = 0; d_valid = 0; d_op = OP_LW; d_addr = 0; d_wdata = 0; d_rt_old = 0;
    t_d_valid = 0; t_d_op = OP_LW; t_d_addr = 0; t_waitrequest = 1; t_readdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Hand-derived values that pin the model.
    check("pin_lb_result", m_load(OP_LB, 32'h1003, 32'h80FF_0000, 32'h0), 32'hFFFF_FF80);
    check("pin_lb_be", m_be(0, OP_LB, 32'h1003), 4'b1000);
    check("pin_sh_be", m_be(0, OP_SH, 32'h2002), 4'b1100);
    check("pin_sh_wdata", m_wdata(OP_SH, 32'h1234_ABCD), 32'hABCD_ABCD);
    check("pin_lwl", m_load(OP_LWL, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344), 32'hCCDD_3344);
    check("pin_lwr", m_load(OP_LWR, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344), 32'h11AA_BBCC);
    check("pin_lw_mis", m_mis(0, OP_LW, 32'h4002), 1);

    // Directed cases on the main DUT.
    run_txn(1, 0, OP_LB, 32'h1003, 0, 0, 0, 32'h80FF_0000, 0, 0, 0, ld, li);
    check("lb_latency", ld, 3);
    run_txn(1, 0, OP_SH, 32'h2002, 0, 32'h1234_ABCD, 0, 0, 0, 0, 0, ld, li);
    check("sh_latency", ld, 3);
    run_txn(1, 0, OP_LWL, 32'h3001, 0, 0, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 0, ld, li);
    run_txn(1, 0, OP_LWR, 32'h3001, 0, 0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 0, ld, li);
    run_txn(1, 0, OP_LW, 32'h4002, 0, 0, 0, 0, 0, 0, 0, ld, li);
    check("lw_mis_latency", ld, 2);
    run_txn(1, 0, OP_LW, 32'h5000, 0, 0, 0, 32'hDEAD_BEEF, 0, 20, 0, ld, li);
    check("stall20_latency", ld, 23);
    run_txn(1, 1, OP_LW, 32'h6000, 32'h7000, 0, 0, 32'h1111_2222, 32'h3333_4444, 0, 0, ld, li);
    check("both_data_latency", ld, 3);
    check("both_fetch_latency", li, 6);
    run_txn(0, 1, OP_LW, 0, 32'h7002, 0, 0, 0, 0, 0, 0, ld, li);
    check("fetch_mis_latency", li, 2);

    // Timeout instance: 3 stalls completes, held waitrequest aborts after 4.
    tmo_run(3, 32'hCAFE_F00D, rhi, got, err, dat, ld);
    check("tmo3_read_cycles", rhi, 4);
    check("tmo3_ready", got, 1);
    check("tmo3_err", err, 0);
    check("tmo3_rdata", dat, 32'hCAFE_F00D);
    tmo_run(1000, 32'h0, rhi, got, err, dat, ld);
    check("tmo_read_cycles", rhi, 4);
    check("tmo_ready", got, 1);
    check("tmo_err", err, 1);
    check("tmo_latency", ld, 6);

    // Randomised traffic.
    for (n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 9);
      hd = (mode != 0);
      hi = (mode == 0) || (mode >= 7);
      op = mem_op_t'($urandom_range(0, 9));
      da = $urandom;
      ia = $urandom;
      if ($urandom_range(0, 1) == 1) da[1:0] = 2'b00;
      if ($urandom_range(0, 2) != 0) ia[1:0] = 2'b00;
      run_txn(hd, hi, op, da, ia, $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? $urandom_range(3, 8) : $urandom_range(0, 2),
              $urandom_range(0, 3), ld, li);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset while a read is stalled on the bus.
    @(posedge clk); #1;
    chk_en = 1'b0;
    p = cyc;
    fill(0, OP_LW, 32'h500, 0, 0, 32'h0, 6, p, r);
    d_valid = 1'b1; d_op = OP_LW; d_addr = 32'h500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstbus_read_before", read, 1);
    reset = 1'b1;
    d_valid = 1'b0;
    @(posedge clk); #1;
    check("rstbus_read_after", read, 0);
    reset = 1'b0;
    saw = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (d_ready || i_ready || read) saw = 1;
    end
    check("rstbus_no_ready", saw, 0);
    sched.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_ctrl.md
# mips_cpu_bus_ctrl

Two-channel Avalon-MM bus master for the multicycle MIPS core, placed between the control/datapath and the single memory port. It serves instruction fetches and data loads/stores with fixed data-over-fetch priority. It generates byte enables and write-lane replication, and performs all load alignment: sign/zero extension plus the LWL/LWR merge. Unlike the waitrequest stall in the control FSM, it adds misalignment checks and a parametrised waitrequest timeout.

## Interface
- ADDR_W, 32, byte-address width; data width fixed at 32 (4 lanes)
- WAIT_MAX, 0, max waitrequest-stalled cycles before abort; 0 = no timeout
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_valid  in  1  fetch request; held until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle response strobe, fetch
- d_valid  in  1  data request; held until d_ready
- d_op  in  4  mem_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data (rt)
- d_rt_old  in  32  current rt value, for LWL/LWR merge
- d_ready  out  1  one-cycle response strobe, data
- rsp_rdata  out  32  aligned load result / fetched word; valid with a ready strobe
- rsp_err  out  1  misaligned or timed-out access; valid with a ready strobe
- address  out  ADDR_W  bus address, word aligned (bits [1:0] = 0)
- read, write  out  1  bus commands
- byteenable  out  4  lane enables
- writedata  out  32  bus write data
- readdata  in  32  bus read data
- waitrequest  in  1  slave stall

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if d_valid, grant data; else if i_valid, grant fetch. Latch op, address, wdata and rt_old. Misaligned requests go straight to RESP with err=1 and issue no bus cycle. All others go to BUS.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW or fetch with addr[1:0]≠0. LWL/LWR are never misaligned.
- BUS: read/write asserted from the latched request. On waitrequest=0, latch readdata and go to RESP. The stall counter increments each cycle waitrequest=1. If WAIT_MAX≠0 and counter = WAIT_MAX, drop the command and go to RESP with err=1.
- RESP: pulse the granted channel's ready for exactly 1 cycle with rsp_rdata/rsp_err, then go to IDLE.
- Little-endian lanes. k = addr[1:0].
- Byte enables: B → 1<<k; H → 0011<<(2·addr[1]); W/LWL/LWR/fetch → 1111.
- Write lanes: SB replicates byte ×4; SH replicates half ×2; SW passes through.
- LB/LBU: lane k, sign/zero extended. LH/LHU: half at addr[1], sign/zero extended. LW: full word.
- LWL: bytes 0..k of the word go to result bytes 3-k..3; lower bytes come from rt_old.
- LWR: bytes k..3 go to result bytes 0..3-k; upper bytes come from rt_old.
- Stores return rsp_rdata = 0.

## Timing
- Reset values: i_ready=d_ready=0, read=write=0, byteenable=0, address=0, writedata=0, rsp_rdata=0, rsp_err=0, counter=0, state=IDLE.
- Latency from valid to ready, no stall: 3 cycles (accept, BUS, RESP). Each waitrequest cycle adds 1. Misaligned requests take 2 cycles.
- Bus outputs are registered and stable for the whole BUS state.
- Requester must hold valid and fields stable until ready. Valid may be deasserted in the ready cycle, and the block never re-accepts the same request.
- Simultaneous i_valid and d_valid: data is served first. The fetch stays pending and is accepted in the IDLE cycle after the data RESP.
- Reset mid-BUS: read/write drop at the next edge, no ready strobe, state=IDLE.
- Timeout abort deasserts the command while waitrequest=1. This is an intentional protocol break, flagged by rsp_err.

## Structure
- mips_cpu_pkg: mem_op_t enum (4-bit), bus_state_t, and lane-mask constants.
- Sub-module mips_cpu_load_align: combinational extract/extend/merge from (op, addr[1:0], readdata, rt_old) to result.
- Top level holds the FSM, arbiter, stall counter ($clog2(WAIT_MAX+1) bits, min 1), and write-lane and byteenable logic.

## Test plan
- LB at 0x1003, readdata=0x80FF_0000 → byteenable=1000, address=0x1000, rsp_rdata=0xFFFF_FF80, d_ready 3 cycles after d_valid.
- SH at 0x2002, d_wdata=0x1234_ABCD → write=1, byteenable=1100, writedata=0xABCD_ABCD, rsp_err=0.
- LWL at 0x3001, readdata=0xAABB_CCDD, rt_old=0x1122_3344 → 0xCCDD_3344. LWR same inputs → 0x11AA_BBCC.
- LW at 0x4002 → no read asserted, d_ready after 2 cycles, rsp_err=1.
- WAIT_MAX=4, waitrequest held high → read drops after 4 stall cycles, rsp_err=1. WAIT_MAX=0 with 20 stall cycles → completes normally on cycle 23.
- i_valid and d_valid together → data served first, fetch i_ready follows. Reset asserted in BUS → read=0 next cycle, no ready strobe.
